alu_exec_unit: RTL and testbench
================================

// Module: alu_exec_unit
// PURPOSE
//  Execute-stage ALU directly downstream of the ALU control decoder. Consumes its 4-bit
//  operation_code plus two register operands and returns a registered result, zero flag
//  and NZCV flags through a start/done handshake.
//  Single-cycle ops complete in one clock. The optional iterative multiply holds busy for
//  WIDTH+1 cycles, and the pipeline stalls on busy.
// PARAMETERS
//  WIDTH  64  operand/result width in bits (>=8)
// PORTS
//  clk             in   1      single clock, all state on rising edge
//  rst             in   1      synchronous reset, active-high
//  start           in   1      request; sampled only when busy=0
//  operation_code  in   4      op select from ALU control
//  a               in   WIDTH  operand A (Rn)
//  b               in   WIDTH  operand B (Rm / immediate)
//  result          out  WIDTH  registered result, held until next completion
//  zero            out  1      result==0, registered with result
//  flags           out  4      {N,Z,C,V}, registered with result
//  busy            out  1      high while an op is in flight
//  done            out  1      one-cycle pulse; result/zero/flags valid from this cycle
//  illegal         out  1      one-cycle pulse with done for an unsupported operation_code
// BEHAVIOUR
//  - Reset: result=0, zero=1, flags=4'b0100, busy=0, done=0, illegal=0, FSM=IDLE.
//    rst wins over every other input and aborts an in-flight multiply; no done is issued.
//  - FSM states: IDLE, EXEC, MUL (MUL exists only with the macro).
//    - IDLE + start: latch a, b, operation_code; busy=1 next cycle; go to EXEC, or MUL for op 1000.
//    - EXEC: compute, register outputs, done=1 for one cycle, busy=0; return to IDLE.
//    - Latency: start at edge N -> done high during the cycle after edge N+1.
//  - start while busy=1 is ignored; operand changes while busy have no effect.
//  - start may be asserted in the same cycle done is high; it is accepted, giving back-to-back
//    ops at 1 per 2 cycles.
//  - Operation codes:
//    - 0000 AND: a & b
//    - 0001 ORR: a | b
//    - 0010 ADD: a + b, C = carry-out, V = signed overflow
//    - 0110 SUB: a - b computed as a + ~b + 1, C = NOT borrow (ARM convention), V = signed overflow
//    - 0111 PASS_B: result = b (CBZ path; zero reflects b)
//    - 1100 NOR: ~(a | b)
//    - 1000 MUL: low WIDTH bits of a*b, unsigned (macro only)
//  - N = result[WIDTH-1]; Z = zero. C and V are 0 for every op except ADD and SUB.
//  - Arithmetic wraps modulo 2^WIDTH; no saturation.
//  - Unsupported code, including 1000 without the macro: result=0, zero=1, flags=4'b0100,
//    illegal=1 and done=1 on the normal single-cycle schedule.
// CONFIGURATION
//  ALU_EXEC_MUL_EN defined:
//   - MUL state is an iterative shift-add, one multiplier bit per cycle, using a
//     log2(WIDTH)+1-bit counter.
//   - busy held for WIDTH cycles in MUL, then one EXEC cycle.
//   - done is high during the cycle after edge N+WIDTH+1.
//   - Flags: N and Z from result, C=V=0.
//  ALU_EXEC_MUL_EN undefined:
//   - No MUL state, counter or accumulator is synthesised.
//   - op 1000 is illegal as above.
// TESTING
//  1. rst=1 for 2 cycles while start=1 -> result=0, zero=1, flags=0100, busy=0, done never pulses.
//  2. ADD a=64'h7FFF_FFFF_FFFF_FFFF, b=1 -> result=64'h8000_0000_0000_0000, flags=1001,
//     done exactly 1 cycle after the accepting edge.
//  3. SUB a=5, b=5 -> result=0, zero=1, flags=0110.
//     SUB a=0, b=1 -> result=all ones, flags=1000.
//  4. start held high for 6 cycles with AND a=F0, b=3C -> three accepted ops, each result=30,
//     done pulses on alternating cycles.
//  5. With ALU_EXEC_MUL_EN: MUL a=12345, b=678 -> result=8369910, done at edge N+65.
//     Assert rst at edge N+20 -> no done, outputs at reset values.
//  6. Without the macro: op 1000, then op 0011 -> each gives illegal=1, done=1, result=0;
//     a following ORR a=1, b=2 -> result=3, illegal=0.

Source files
------------

// File: rtl/alu_exec_unit.sv
// Execute-stage ALU with start/done handshake, registered result, zero flag and NZCV flags.
// Define ALU_EXEC_MUL_EN to build the iterative shift-add multiply for operation_code 1000.
module alu_exec_unit #(
  parameter int WIDTH = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [3:0]       operation_code,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic [3:0]       flags,
  output logic             busy,
  output logic             done,
  output logic             illegal
);

  localparam logic [3:0] OP_AND  = 4'b0000;
  localparam logic [3:0] OP_ORR  = 4'b0001;
  localparam logic [3:0] OP_ADD  = 4'b0010;
  localparam logic [3:0] OP_SUB  = 4'b0110;
  localparam logic [3:0] OP_PASS = 4'b0111;
  localparam logic [3:0] OP_NOR  = 4'b1100;

  // Handshake: start is taken only in IDLE (busy=0); done pulses for one cycle with
  // result/zero/flags/illegal valid from that cycle and held until the next done.
`ifdef ALU_EXEC_MUL_EN
  localparam logic [3:0] OP_MUL = 4'b1000;
  localparam int CNT_W = $clog2(WIDTH) + 1;
  typedef enum logic [1:0] {S_IDLE, S_EXEC, S_MUL} state_t;
  logic [WIDTH-1:0] acc_q, acc_d, mcand_q, mcand_d, mplier_q, mplier_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
`else
  typedef enum logic [1:0] {S_IDLE, S_EXEC} state_t;
`endif

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, result_q, result_d;
  logic [3:0]       op_q, op_d, flags_q, flags_d;
  logic             busy_q, busy_d, done_q, done_d, illegal_q, illegal_d;

  logic [WIDTH:0]   sum;
  logic [WIDTH-1:0] b_eff, alu_res;
  logic             is_sub, alu_c, alu_v, alu_ill;

  // SUB shares the adder as a + ~b + 1, so carry-out is NOT borrow.
  always_comb begin
    is_sub  = (op_q == OP_SUB);
    b_eff   = is_sub ? ~b_q : b_q;
    sum     = {1'b0, a_q} + {1'b0, b_eff} + {{WIDTH{1'b0}}, is_sub};
    alu_res = '0;
    alu_c   = 1'b0;
    alu_v   = 1'b0;
    alu_ill = 1'b0;
    case (op_q)
      OP_AND:  alu_res = a_q & b_q;
      OP_ORR:  alu_res = a_q | b_q;
      OP_PASS: alu_res = b_q;
      OP_NOR:  alu_res = ~(a_q | b_q);
      OP_ADD, OP_SUB: begin
        alu_res = sum[WIDTH-1:0];
        alu_c   = sum[WIDTH];
        alu_v   = (a_q[WIDTH-1] == b_eff[WIDTH-1]) && (sum[WIDTH-1] != a_q[WIDTH-1]);
      end
`ifdef ALU_EXEC_MUL_EN
      OP_MUL:  alu_res = acc_q;
`endif
      default: alu_ill = 1'b1;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    a_d       = a_q;
    b_d       = b_q;
    op_d      = op_q;
    result_d  = result_q;
    flags_d   = flags_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    illegal_d = 1'b0;
`ifdef ALU_EXEC_MUL_EN
    acc_d     = acc_q;
    mcand_d   = mcand_q;
    mplier_d  = mplier_q;
    cnt_d     = cnt_q;
`endif
    case (state_q)
      S_IDLE: if (start) begin
        a_d     = a;
        b_d     = b;
        op_d    = operation_code;
        busy_d  = 1'b1;
        state_d = S_EXEC;
`ifdef ALU_EXEC_MUL_EN
        if (operation_code == OP_MUL) begin
          state_d  = S_MUL;
          acc_d    = '0;
          mcand_d  = a;
          mplier_d = b;
          cnt_d    = '0;
        end
`endif
      end
      S_EXEC: begin
        result_d  = alu_res;
        flags_d   = {alu_res[WIDTH-1], alu_res == '0, alu_c, alu_v};
        illegal_d = alu_ill;
        done_d    = 1'b1;
        busy_d    = 1'b0;
        state_d   = S_IDLE;
      end
`ifdef ALU_EXEC_MUL_EN
      // One multiplier bit per cycle; WIDTH cycles here, then EXEC publishes acc_q.
      S_MUL: begin
        if (mplier_q[0]) acc_d = acc_q + mcand_q;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + 1'b1;
        if (cnt_q == CNT_W'(WIDTH - 1)) state_d = S_EXEC;
      end
`endif
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      a_q       <= '0;
      b_q       <= '0;
      op_q      <= '0;
      result_q  <= '0;
      flags_q   <= 4'b0100;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      illegal_q <= 1'b0;
`ifdef ALU_EXEC_MUL_EN
      acc_q     <= '0;
      mcand_q   <= '0;
      mplier_q  <= '0;
      cnt_q     <= '0;
`endif
    end else begin
      state_q   <= state_d;
      a_q       <= a_d;
      b_q       <= b_d;
      op_q      <= op_d;
      result_q  <= result_d;
      flags_q   <= flags_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      illegal_q <= illegal_d;
`ifdef ALU_EXEC_MUL_EN
      acc_q     <= acc_d;
      mcand_q   <= mcand_d;
      mplier_q  <= mplier_d;
      cnt_q     <= cnt_d;
`endif
    end
  end

  assign result  = result_q;
  assign zero    = flags_q[2];
  assign flags   = flags_q;
  assign busy    = busy_q;
  assign done    = done_q;
  assign illegal = illegal_q;

endmodule

// File: tb/tb_alu_exec_unit.sv
// Directed-vector bench for alu_exec_unit; the MUL checks build only with ALU_EXEC_MUL_EN.
module tb_alu_exec_unit;
  localparam int W = 64;
  localparam logic [W-1:0] ONES = {W{1'b1}};
  localparam logic [W-1:0] MSB  = {1'b1, {(W-1){1'b0}}};

  logic         clk = 1'b0;
  logic         rst, start;
  logic [3:0]   operation_code, flags;
  logic [W-1:0] a, b, result;
  logic         zero, busy, done, illegal;

  int n_tests = 0;
  int n_fail  = 0;
  logic [W-1:0] exp_q[$];

  // clock / reset
  always #5 clk = ~clk;

  alu_exec_unit #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .start(start), .operation_code(operation_code),
    .a(a), .b(b), .result(result), .zero(zero), .flags(flags),
    .busy(busy), .done(done), .illegal(illegal)
  );

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_result"}, result, '0);
    check({tag, "_zero"}, W'(zero), W'(1));
    check({tag, "_flags"}, W'(flags), W'(4'b0100));
    check({tag, "_busy"}, W'(busy), '0);
    check({tag, "_done"}, W'(done), '0);
    check({tag, "_illegal"}, W'(illegal), '0);
  endtask

  // driver: one single-cycle op, checked at the accepting edge and the done edge
  task automatic run_op(input string tag, input logic [3:0] op, input logic [W-1:0] av,
                        input logic [W-1:0] bv, input logic [W-1:0] exp_res,
                        input logic [3:0] exp_flags, input logic exp_ill);
    @(negedge clk);
    start = 1'b1; operation_code = op; a = av; b = bv;
    exp_q.push_back(exp_res);
    @(posedge clk); #1;
    start = 1'b0;
    a = {$urandom, $urandom};
    b = {$urandom, $urandom};
    check({tag, "_busy_acc"}, W'(busy), W'(1));
    check({tag, "_done_acc"}, W'(done), '0);
    @(posedge clk); #1;
    check({tag, "_done"}, W'(done), W'(1));
    check({tag, "_busy"}, W'(busy), '0);
    check({tag, "_result"}, result, exp_q.pop_front());
    check({tag, "_flags"}, W'(flags), W'(exp_flags));
    check({tag, "_zero"}, W'(zero), W'(exp_flags[2]));
    check({tag, "_illegal"}, W'(illegal), W'(exp_ill));
  endtask

  initial begin
    int n_done;
    rst = 1'b1; start = 1'b1; operation_code = 4'b0010; a = 64'd1; b = 64'd1;
    // reset held with start asserted
    for (int i = 0; i < 2; i++) begin
      @(posedge clk); #1;
      check("rst_done", W'(done), '0);
      check("rst_busy", W'(busy), '0);
    end
    check_reset_outputs("rst");
    @(negedge clk);
    rst = 1'b0; start = 1'b0;
    @(posedge clk); #1;
    check("post_rst_done", W'(done), '0);

    run_op("add_ovf", 4'b0010, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 64'h8000_0000_0000_0000, 4'b1001, 1'b0);
    @(posedge clk); #1;
    check("add_ovf_done_drop", W'(done), '0);
    run_op("add_carry", 4'b0010, ONES, 64'd1, 64'd0, 4'b0110, 1'b0);
    run_op("sub_eq", 4'b0110, 64'd5, 64'd5, 64'd0, 4'b0110, 1'b0);
    run_op("sub_neg", 4'b0110, 64'd0, 64'd1, ONES, 4'b1000, 1'b0);
    run_op("sub_ovf", 4'b0110, MSB, 64'd1, 64'h7FFF_FFFF_FFFF_FFFF, 4'b0011, 1'b0);
    run_op("and", 4'b0000, 64'hFF00_FF00_1234_5678, 64'h0FF0_0FF0_FFFF_0000, 64'h0F00_0F00_1234_0000, 4'b0000, 1'b0);
    run_op("orr_neg", 4'b0001, MSB, 64'h1, 64'h8000_0000_0000_0001, 4'b1000, 1'b0);
    run_op("nor", 4'b1100, 64'd0, 64'd0, ONES, 4'b1000, 1'b0);
    run_op("pass_zero", 4'b0111, 64'hFF, 64'd0, 64'd0, 4'b0100, 1'b0);
    run_op("pass_b", 4'b0111, 64'd0, 64'hABCD, 64'hABCD, 4'b0000, 1'b0);

    // start held for 6 edges: accepts on alternating edges
    @(negedge clk);
    start = 1'b1; operation_code = 4'b0000; a = 64'hF0; b = 64'h3C;
    n_done = 0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      check("b2b_done", W'(done), W'(i % 2));
      if (done) begin
        n_done++;
        check("b2b_result", result, 64'h30);
      end
    end
    start = 1'b0;
    check("b2b_count", W'(n_done), W'(3));
    @(posedge clk); #1;
    check("b2b_idle_busy", W'(busy), '0);
    check("b2b_idle_done", W'(done), '0);

`ifdef ALU_EXEC_MUL_EN
    begin
      int lat;
      @(negedge clk);
      start = 1'b1; operation_code = 4'b1000; a = 64'd12345; b = 64'd678;
      @(posedge clk); #1;
      start = 1'b0; a = '0; b = '0;
      lat = 0;
      for (int i = 1; i <= 200 && lat == 0; i++) begin
        @(posedge clk); #1;
        if (done) lat = i;
        else check("mul_busy", W'(busy), W'(1));
      end
      check("mul_latency", W'(lat), W'(W + 1));
      check("mul_result", result, 64'd8369910);
      check("mul_flags", W'(flags), '0);
      check("mul_illegal", W'(illegal), '0);
      // abort by reset at edge N+20
      @(negedge clk);
      start = 1'b1; operation_code = 4'b1000; a = 64'd12345; b = 64'd678;
      @(posedge clk); #1;
      start = 1'b0;
      for (int i = 1; i < 20; i++) begin
        @(posedge clk); #1;
        check("mul_abort_pre_done", W'(done), '0);
      end
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      check_reset_outputs("mul_abort");
      n_done = 0;
      for (int i = 0; i < 80; i++) begin
        @(posedge clk); #1;
        if (done) n_done++;
      end
      check("mul_abort_no_done", W'(n_done), '0);
      check_reset_outputs("mul_abort_late");
    end
`else
    run_op("ill_1000", 4'b1000, 64'd7, 64'd9, 64'd0, 4'b0100, 1'b1);
    run_op("ill_0011", 4'b0011, 64'd7, 64'd9, 64'd0, 4'b0100, 1'b1);
    run_op("orr_after_ill", 4'b0001, 64'd1, 64'd2, 64'd3, 4'b0000, 1'b0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
